// File: rtl/zuc_sbox_arb.sv
// Shared ZUC S-box layer: one S0 and one S1 lookup, time-shared between two
// 32-bit requesters by a round-robin (or fixed-priority) arbiter over two phases.

module zuc_s0 (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Byte x sits at bits [(255-x)*8 +: 8], i.e. offset {~x, 3'b000}.
    localparam logic [2047:0] TAB = {
        256'h3e725b47cae0003304d1549809b96dcb_7b1bf932af9d6aa5b82dfc1d08530390,
        256'h4d4e8499e4ced991ddb685488b296eac_cdc1f81e734369c6b5bdfd396320d438,
        256'h767db2a7cfed57c5f32cbb142106559b_e3ef5e314f7f5aa40d8251495fba581c,
        256'h4a16d517a892241f8cffd8ae2e01d3ad_3b4bda46ebc9de9a8f87d73a806f2fc8,
        256'hb1b437f70a2213287ccc3c89c7c39656_07bf7ef00b2b975235417961a64c10fe,
        256'hbc2695888ab0a3fbc01894f2e1e5e95d_d0dc1166645cec59427512f5749caa23,
        256'h0e86abbe2a02e767e644a26cc2939ff1_f6fa36d250689e6271153dd640c4e20f,
        256'h8e83776b25053f0c30ea70b7a1e8a965_8d271adb81b3a0f4457a19dfee783460
    };

    logic [10:0] idx_s;

    assign idx_s = {~din, 3'b000};
    assign dout  = TAB[idx_s +: 8];
endmodule

module zuc_s1 (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [2047:0] TAB = {
        256'h55c263713bc847869f3cda5b29aafd77_8cc5940ca61a1300e3a8167240f9f842,
        256'h4426689681d9453e1076c6a78b3943e1_3ab5562ac06db3052266bfdc0bfa6248,
        256'hdd20110636c9c1cff62752bb69f5d487_7f844cd29c57a4bc4f9adffed68d7aeb,
        256'h2b53d85ca11417fb23d57d3067730809_eeb7703f61b2198e4ee54b938f5ddba9,
        256'hadf1ae2ecb0dfcf42d466e1d97e8d1e9_4d37a5755e839eab829db91ce0cd4989,
        256'h01b6bd5824a25f387899159050b895e4_d091c7ceed0fb46fa0ccf0024a79c3de,
        256'ha3efea51e66b18ec1b2c80f774e7ff21_5a6a541e41319235c433070aba7e0e34,
        256'h88b1987cf33d606c7bcad31f32650428_64be859b2f598ad7b025acaf1203e2f2
    };

    logic [10:0] idx_s;

    assign idx_s = {~din, 3'b000};
    assign dout  = TAB[idx_s +: 8];
endmodule

module zuc_sbox_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_vld,
    input  logic [31:0] req0_din,
    output logic        req0_rdy,
    input  logic        req1_vld,
    input  logic [31:0] req1_din,
    output logic        req1_rdy,
    output logic        rsp0_vld,
    output logic        rsp1_vld,
    output logic [31:0] rsp_dout,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] word_r;
    logic [15:0] hi_r;
    logic        owner_r;
    logic        last_r;
    logic        window_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        accept_s;
    logic [7:0]  s0_in_s;
    logic [7:0]  s1_in_s;
    logic [7:0]  s0_out_s;
    logic [7:0]  s1_out_s;

    zuc_s0 u_s0 (.din(s0_in_s), .dout(s0_out_s));
    zuc_s1 u_s1 (.din(s1_in_s), .dout(s1_out_s));

    assign window_s = (state_r == IDLE) || (state_r == PH1);

    // Grant selection inside the accept window; last_r breaks ties in round-robin mode.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (window_s) begin
            if (req0_vld && req1_vld) begin
                if ((RR_EN == 1'b1) && (last_r == 1'b0)) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end else if (req0_vld) begin
                gnt0_s = 1'b1;
            end else if (req1_vld) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // The handshake is combinational, so rdy must be forced low while reset is asserted.
    assign req0_rdy = gnt0_s & rst_n;
    assign req1_rdy = gnt1_s & rst_n;
    assign accept_s = (req0_vld & req0_rdy) | (req1_vld & req1_rdy);

    // Next-state logic for the two-phase substitution sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = PH0;
                else          state_s = IDLE;
            end
            PH0: state_s = PH1;
            PH1: begin
                if (accept_s) state_s = PH0;
                else          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // S-box operand mux: upper half of the word in PH0, lower half otherwise.
    always_comb begin
        s0_in_s = word_r[15:8];
        s1_in_s = word_r[7:0];
        if (state_r == PH0) begin
            s0_in_s = word_r[31:24];
            s1_in_s = word_r[23:16];
        end else begin
            s0_in_s = word_r[15:8];
            s1_in_s = word_r[7:0];
        end
    end

    // Control state, accepted word and arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            word_r  <= 32'd0;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            if (accept_s) begin
                word_r  <= gnt1_s ? req1_din : req0_din;
                owner_r <= gnt1_s;
                last_r  <= gnt1_s;
            end
        end
    end

    // Datapath: upper result half in PH0, full result and owner pulse at the end of PH1.
    // In a back-to-back PH1 the pulse still uses owner_r before it is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r     <= 16'd0;
            rsp_dout <= 32'd0;
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
        end else begin
            if (state_r == PH0) begin
                hi_r <= {s0_out_s, s1_out_s};
            end
            if (state_r == PH1) begin
                rsp_dout <= {hi_r, s0_out_s, s1_out_s};
                rsp0_vld <= ~owner_r;
                rsp1_vld <= owner_r;
            end else begin
                rsp0_vld <= 1'b0;
                rsp1_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_zuc_sbox_arb.sv
// Directed and randomised bench for zuc_sbox_arb with a per-requester
// scoreboard of expected substituted words.

module tb_zuc_sbox_arb;
    localparam logic [7:0] T0 [256] = '{
        8'h3e,8'h72,8'h5b,8'h47,8'hca,8'he0,8'h00,8'h33,8'h04,8'hd1,8'h54,8'h98,8'h09,8'hb9,8'h6d,8'hcb,
        8'h7b,8'h1b,8'hf9,8'h32,8'haf,8'h9d,8'h6a,8'ha5,8'hb8,8'h2d,8'hfc,8'h1d,8'h08,8'h53,8'h03,8'h90,
        8'h4d,8'h4e,8'h84,8'h99,8'he4,8'hce,8'hd9,8'h91,8'hdd,8'hb6,8'h85,8'h48,8'h8b,8'h29,8'h6e,8'hac,
        8'hcd,8'hc1,8'hf8,8'h1e,8'h73,8'h43,8'h69,8'hc6,8'hb5,8'hbd,8'hfd,8'h39,8'h63,8'h20,8'hd4,8'h38,
        8'h76,8'h7d,8'hb2,8'ha7,8'hcf,8'hed,8'h57,8'hc5,8'hf3,8'h2c,8'hbb,8'h14,8'h21,8'h06,8'h55,8'h9b,
        8'he3,8'hef,8'h5e,8'h31,8'h4f,8'h7f,8'h5a,8'ha4,8'h0d,8'h82,8'h51,8'h49,8'h5f,8'hba,8'h58,8'h1c,
        8'h4a,8'h16,8'hd5,8'h17,8'ha8,8'h92,8'h24,8'h1f,8'h8c,8'hff,8'hd8,8'hae,8'h2e,8'h01,8'hd3,8'had,
        8'h3b,8'h4b,8'hda,8'h46,8'heb,8'hc9,8'hde,8'h9a,8'h8f,8'h87,8'hd7,8'h3a,8'h80,8'h6f,8'h2f,8'hc8,
        8'hb1,8'hb4,8'h37,8'hf7,8'h0a,8'h22,8'h13,8'h28,8'h7c,8'hcc,8'h3c,8'h89,8'hc7,8'hc3,8'h96,8'h56,
        8'h07,8'hbf,8'h7e,8'hf0,8'h0b,8'h2b,8'h97,8'h52,8'h35,8'h41,8'h79,8'h61,8'ha6,8'h4c,8'h10,8'hfe,
        8'hbc,8'h26,8'h95,8'h88,8'h8a,8'hb0,8'ha3,8'hfb,8'hc0,8'h18,8'h94,8'hf2,8'he1,8'he5,8'he9,8'h5d,
        8'hd0,8'hdc,8'h11,8'h66,8'h64,8'h5c,8'hec,8'h59,8'h42,8'h75,8'h12,8'hf5,8'h74,8'h9c,8'haa,8'h23,
        8'h0e,8'h86,8'hab,8'hbe,8'h2a,8'h02,8'he7,8'h67,8'he6,8'h44,8'ha2,8'h6c,8'hc2,8'h93,8'h9f,8'hf1,
        8'hf6,8'hfa,8'h36,8'hd2,8'h50,8'h68,8'h9e,8'h62,8'h71,8'h15,8'h3d,8'hd6,8'h40,8'hc4,8'he2,8'h0f,
        8'h8e,8'h83,8'h77,8'h6b,8'h25,8'h05,8'h3f,8'h0c,8'h30,8'hea,8'h70,8'hb7,8'ha1,8'he8,8'ha9,8'h65,
        8'h8d,8'h27,8'h1a,8'hdb,8'h81,8'hb3,8'ha0,8'hf4,8'h45,8'h7a,8'h19,8'hdf,8'hee,8'h78,8'h34,8'h60
    };
    localparam logic [7:0] T1 [256] = '{
        8'h55,8'hc2,8'h63,8'h71,8'h3b,8'hc8,8'h47,8'h86,8'h9f,8'h3c,8'hda,8'h5b,8'h29,8'haa,8'hfd,8'h77,
        8'h8c,8'hc5,8'h94,8'h0c,8'ha6,8'h1a,8'h13,8'h00,8'he3,8'ha8,8'h16,8'h72,8'h40,8'hf9,8'hf8,8'h42,
        8'h44,8'h26,8'h68,8'h96,8'h81,8'hd9,8'h45,8'h3e,8'h10,8'h76,8'hc6,8'ha7,8'h8b,8'h39,8'h43,8'he1,
        8'h3a,8'hb5,8'h56,8'h2a,8'hc0,8'h6d,8'hb3,8'h05,8'h22,8'h66,8'hbf,8'hdc,8'h0b,8'hfa,8'h62,8'h48,
        8'hdd,8'h20,8'h11,8'h06,8'h36,8'hc9,8'hc1,8'hcf,8'hf6,8'h27,8'h52,8'hbb,8'h69,8'hf5,8'hd4,8'h87,
        8'h7f,8'h84,8'h4c,8'hd2,8'h9c,8'h57,8'ha4,8'hbc,8'h4f,8'h9a,8'hdf,8'hfe,8'hd6,8'h8d,8'h7a,8'heb,
        8'h2b,8'h53,8'hd8,8'h5c,8'ha1,8'h14,8'h17,8'hfb,8'h23,8'hd5,8'h7d,8'h30,8'h67,8'h73,8'h08,8'h09,
        8'hee,8'hb7,8'h70,8'h3f,8'h61,8'hb2,8'h19,8'h8e,8'h4e,8'he5,8'h4b,8'h93,8'h8f,8'h5d,8'hdb,8'ha9,
        8'had,8'hf1,8'hae,8'h2e,8'hcb,8'h0d,8'hfc,8'hf4,8'h2d,8'h46,8'h6e,8'h1d,8'h97,8'he8,8'hd1,8'he9,
        8'h4d,8'h37,8'ha5,8'h75,8'h5e,8'h83,8'h9e,8'hab,8'h82,8'h9d,8'hb9,8'h1c,8'he0,8'hcd,8'h49,8'h89,
        8'h01,8'hb6,8'hbd,8'h58,8'h24,8'ha2,8'h5f,8'h38,8'h78,8'h99,8'h15,8'h90,8'h50,8'hb8,8'h95,8'he4,
        8'hd0,8'h91,8'hc7,8'hce,8'hed,8'h0f,8'hb4,8'h6f,8'ha0,8'hcc,8'hf0,8'h02,8'h4a,8'h79,8'hc3,8'hde,
        8'ha3,8'hef,8'hea,8'h51,8'he6,8'h6b,8'h18,8'hec,8'h1b,8'h2c,8'h80,8'hf7,8'h74,8'he7,8'hff,8'h21,
        8'h5a,8'h6a,8'h54,8'h1e,8'h41,8'h31,8'h92,8'h35,8'hc4,8'h33,8'h07,8'h0a,8'hba,8'h7e,8'h0e,8'h34,
        8'h88,8'hb1,8'h98,8'h7c,8'hf3,8'h3d,8'h60,8'h6c,8'h7b,8'hca,8'hd3,8'h1f,8'h32,8'h65,8'h04,8'h28,
        8'h64,8'hbe,8'h85,8'h9b,8'h2f,8'h59,8'h8a,8'hd7,8'hb0,8'h25,8'hac,8'haf,8'h12,8'h03,8'he2,8'hf2
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_vld = 1'b0, req1_vld = 1'b0;
    logic [31:0] req0_din = 32'd0, req1_din = 32'd0;
    logic        req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, busy;
    logic [31:0] rsp_dout;
    logic        f0_vld = 1'b0, f1_vld = 1'b0;
    logic [31:0] f0_din = 32'd0, f1_din = 32'd0;
    logic        f0_rdy, f1_rdy, f_rsp0, f_rsp1, f_busy;
    logic [31:0] f_dout;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rsp0 = 0, n_rsp1 = 0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] b2b_w [4] = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};

    always #5 clk = ~clk;

    zuc_sbox_arb #(.RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_din(req0_din), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_din(req1_din), .req1_rdy(req1_rdy),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_dout(rsp_dout), .busy(busy)
    );

    zuc_sbox_arb #(.RR_EN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(f0_vld), .req0_din(f0_din), .req0_rdy(f0_rdy),
        .req1_vld(f1_vld), .req1_din(f1_din), .req1_rdy(f1_rdy),
        .rsp0_vld(f_rsp0), .rsp1_vld(f_rsp1), .rsp_dout(f_dout), .busy(f_busy)
    );

    function automatic logic [31:0] sbox(input logic [31:0] w);
        return {T0[w[31:24]], T1[w[23:16]], T0[w[15:8]], T1[w[7:0]]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop/compare responses first, then push newly accepted words.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            check("rsp_onehot", 32'(rsp0_vld & rsp1_vld), 32'd0);
            if (rsp0_vld) begin
                n_rsp0++;
                check("rsp0_expected", 32'(exp0_q.size() != 0), 32'd1);
                if (exp0_q.size() != 0) check("rsp0_data", rsp_dout, exp0_q.pop_front());
            end
            if (rsp1_vld) begin
                n_rsp1++;
                check("rsp1_expected", 32'(exp1_q.size() != 0), 32'd1);
                if (exp1_q.size() != 0) check("rsp1_data", rsp_dout, exp1_q.pop_front());
            end
            if (req0_vld && req0_rdy) exp0_q.push_back(sbox(req0_din));
            if (req1_vld && req1_rdy) exp1_q.push_back(sbox(req1_din));
        end
    end

    task automatic single(input bit port, input logic [31:0] w, input logic [31:0] expv);
        if (port) begin req1_vld = 1'b1; req1_din = w; end
        else      begin req0_vld = 1'b1; req0_din = w; end
        @(negedge clk);
        check("single_rdy", 32'({req1_rdy, req0_rdy}), port ? 32'd2 : 32'd1);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("single_busy", 32'(busy), 32'(c <= 2));
            check("single_rsp", 32'({rsp1_vld, rsp0_vld}), (c == 3) ? (port ? 32'd2 : 32'd1) : 32'd0);
            if (c >= 3) check("single_dout", rsp_dout, expv);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        a0, a1;
        logic [31:0] e_val;
        int          base0, base1, iss0, iss1, k;

        // Reset state, with a requester already valid.
        req0_vld = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset_rdy", 32'({req1_rdy, req0_rdy}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_vld", 32'({rsp1_vld, rsp0_vld}), 32'd0);
        check("reset_dout", rsp_dout, 32'd0);
        tick();
        req0_vld = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single requests and byte mapping.
        single(1'b0, 32'h00000000, 32'h3e553e55);
        single(1'b1, 32'h01010101, 32'h72c272c2);
        single(1'b0, 32'hff00ff00, 32'h60556055);

        // Round-robin contention: last grant was req0 above, so req1 wins first here.
        req0_vld = 1'b1; req0_din = 32'h11223344;
        req1_vld = 1'b1; req1_din = 32'haabbccdd;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a0 = req0_rdy;
            a1 = req1_rdy;
            e_val = (c % 4 == 0) ? 32'd2 : ((c % 4 == 2) ? 32'd1 : 32'd0);
            check("rr_rdy", 32'({req1_rdy, req0_rdy}), e_val);
            e_val = (c >= 3 && (c - 3) % 4 == 0) ? 32'd2 : ((c >= 3 && (c - 3) % 4 == 2) ? 32'd1 : 32'd0);
            check("rr_rsp", 32'({rsp1_vld, rsp0_vld}), e_val);
            if (c >= 1) check("rr_busy", 32'(busy), 32'd1);
            tick();
            if (a0) req0_din = req0_din + 32'h01010101;
            if (a1) req1_din = req1_din + 32'h13572468;
        end
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        repeat (4) tick();

        // Fixed priority: req0 monopolises while valid.
        f0_vld = 1'b1; f0_din = 32'hdeadbeef;
        f1_vld = 1'b1; f1_din = 32'h0badf00d;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("fix_rdy", 32'({f1_rdy, f0_rdy}), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("fix_rsp", 32'({f_rsp1, f_rsp0}), (c == 3 || c == 5) ? 32'd1 : 32'd0);
            if (c == 3 || c == 5) check("fix_dout0", f_dout, sbox(32'hdeadbeef));
            tick();
        end
        f0_vld = 1'b0;
        @(negedge clk);
        check("fix_rdy_req1", 32'({f1_rdy, f0_rdy}), 32'd2);
        tick();
        f1_vld = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            check("fix_tail_rsp", 32'({f_rsp1, f_rsp0}), (c == 7) ? 32'd1 : ((c == 9) ? 32'd2 : 32'd0));
            if (c == 9) check("fix_dout1", f_dout, sbox(32'h0badf00d));
            tick();
        end
        repeat (2) tick();

        // Back-to-back: four words from req0 with vld held high.
        base0 = n_rsp0;
        k = 0;
        req0_vld = 1'b1; req0_din = b2b_w[0];
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            a0 = req0_rdy;
            check("b2b_rdy", 32'(req0_rdy), 32'((c <= 6) && (c % 2 == 0)));
            check("b2b_rsp", 32'(rsp0_vld), 32'((c == 3) || (c == 5) || (c == 7) || (c == 9)));
            if (c >= 1) check("b2b_busy", 32'(busy), 32'(c <= 8));
            tick();
            if (a0) begin
                k++;
                if (k < 4) req0_din = b2b_w[k];
                else       req0_vld = 1'b0;
            end
        end
        check("b2b_count", 32'(n_rsp0 - base0), 32'd4);
        check("b2b_last_dout", rsp_dout, sbox(32'h76543210));

        // Reset during PH1: everything clears at once, no response for the lost word.
        req0_vld = 1'b1; req0_din = 32'hcafef00d;
        tick();
        req0_vld = 1'b0;
        tick();
        rst_n = 1'b0;
        req0_vld = 1'b1;
        req1_vld = 1'b1; req1_din = 32'h55aa55aa;
        #1;
        check("mid_rst_dout", rsp_dout, 32'd0);
        check("mid_rst_ctl", 32'({busy, rsp1_vld, rsp0_vld, req1_rdy, req0_rdy}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_quiet", 32'({busy, rsp1_vld, rsp0_vld, req1_rdy, req0_rdy}), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_first_grant", 32'({req1_rdy, req0_rdy}), 32'd1);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'({rsp1_vld, rsp0_vld}), (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) check("post_rst_dout", rsp_dout, sbox(32'hcafef00d));
            tick();
        end

        // Random traffic on both ports; vld/din held until accepted.
        base0 = n_rsp0; base1 = n_rsp1; iss0 = 0; iss1 = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a0 = req0_vld && req0_rdy;
            a1 = req1_vld && req1_rdy;
            tick();
            if (!req0_vld || a0) begin
                if ($urandom_range(0, 1) == 1) begin req0_vld = 1'b1; req0_din = $urandom; iss0++; end
                else req0_vld = 1'b0;
            end
            if (!req1_vld || a1) begin
                if ($urandom_range(0, 1) == 1) begin req1_vld = 1'b1; req1_din = $urandom; iss1++; end
                else req1_vld = 1'b0;
            end
        end
        for (int i = 0; i < 20 && (req0_vld || req1_vld); i++) begin
            @(negedge clk);
            a0 = req0_vld && req0_rdy;
            a1 = req1_vld && req1_rdy;
            tick();
            if (a0) req0_vld = 1'b0;
            if (a1) req1_vld = 1'b0;
        end
        check("rand_drained", 32'({req1_vld, req0_vld}), 32'd0);
        repeat (6) tick();
        check("rand_count0", 32'(n_rsp0 - base0), 32'(iss0));
        check("rand_count1", 32'(n_rsp1 - base1), 32'(iss1));
        check("rand_sb_empty", 32'(exp0_q.size() + exp1_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
